pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core (IF, ID, EX, MEM, WB).
- Generates per-stage enables, EX bubble insertion and ID flush.
- Handles load-use hazards against the decode stage, data-memory wait states, branch squash and debug halt/drain.
- Sits beside decode; its en_id drives decode's en input.

Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter.
- DRAIN, 3, cycles EX/MEM/WB remain enabled after halt entry.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  valid instruction held in ID.
- id_rs1  in  5  ID source register 1 address.
- id_rs2  in  5  ID source register 2 address.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_load  in  1  instruction in EX is a load.
- ex_rd  in  5  EX destination register.
- taken  in  1  branch/jump resolved taken in ID this cycle.
- mem_req  in  1  MEM stage issuing a data-memory access.
- mem_ready  in  1  data memory completes the access this cycle.
- halt_req  in  1  debug halt request, level.
- en_if, en_id, en_ex, en_mem, en_wb  out  1 each  stage enables.
- bubble_ex  out  1  load NOP into EX instead of the ID result.
- flush_id  out  1  squash the IF/ID register on its next enabled edge.
- halted  out  1  pipeline fully drained and frozen.
- stall_count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Clock/reset: one clock (clk); reset (rst) is asynchronous and active-high.
- While rst is high:
  - State = RUN, drain counter = 0, stall_count = 0.
  - All en_* = 0, bubble_ex = 1, flush_id = 0, halted = 0.
- States: RUN, LDSTALL, MWAIT, HALT. State is registered; outputs are combinational from state and inputs.
- Definitions:
  - hz = id_valid & ex_load & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
  - mw = mem_req & ~mem_ready.
- RUN priority, highest first:
  - mw: all en_* = 0; next state MWAIT.
  - hz: en_if = en_id = 0; en_ex = en_mem = en_wb = 1; bubble_ex = 1; next state LDSTALL.
  - halt_req: en_if = en_id = 0; en_ex/mem/wb = 1; bubble_ex = 1; drain counter loads DRAIN-1; next state HALT.
  - Otherwise: all en_* = 1, bubble_ex = 0.
- LDSTALL:
  - Lasts exactly one cycle. Outputs are evaluated as RUN, except a second hz is ignored (treated as no hazard).
  - Next state per RUN rules, with hz masked.
- MWAIT:
  - While mw: all en_* = 0, hold state.
  - When mem_ready = 1: outputs and next state exactly as RUN in the same cycle.
- HALT:
  - en_if = en_id = 0, bubble_ex = 1.
  - en_ex/mem/wb = 1 while drain counter != 0; counter decrements each cycle.
  - When the counter reaches 0: en_ex/mem/wb = 0 and halted = 1.
  - halt_req low: return to RUN next cycle, halted = 0, counter cleared. This applies even mid-drain.
  - mem_req is ignored during drain; the drain always completes the full DRAIN cycles.
- Flush: flush_id = taken & en_id. It is 0 whenever en_id = 0, so a taken branch seen while ID is stalled is not flushed until ID advances.
- stall_count increments by 1 on each clk edge where en_id = 0, state != HALT and rst = 0. It saturates at all-ones and never wraps.
- Register x0 never causes a hazard.
- A simultaneous hz and mw takes MWAIT only; hz is re-evaluated on exit.

Test Plan:
- Load-use: ex_load = 1, ex_rd = 5, id_valid = 1, id_uses_rs1 = 1, id_rs1 = 5 -> exactly one cycle with en_id = 0 and bubble_ex = 1, state LDSTALL, then RUN; stall_count = 1.
- x0 / unused source: ex_rd = 0 with id_rs1 = 0, or id_uses_rs2 = 0 with id_rs2 = ex_rd -> no stall, all en_* = 1.
- Memory wait: mem_req = 1, mem_ready = 0 for 4 cycles, then 1 -> all en_* = 0 for 4 cycles, all 1 on the fifth; stall_count = 4. A coincident hz yields MWAIT first, then one LDSTALL.
- Branch: taken = 1 with en_id = 1 -> flush_id = 1 for that cycle. taken = 1 during a load-use stall -> flush_id = 0.
- Halt: halt_req rises in RUN -> en_ex/mem/wb high for 3 cycles with bubble_ex = 1, then halted = 1 and all en_* = 0. Dropping halt_req after 1 drain cycle -> RUN next cycle, halted never asserted.
- Async reset mid-MWAIT: assert rst between edges -> en_* drop to 0 immediately and stall_count = 0. After release the controller is in RUN.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage core: stage enables, EX bubble, ID flush,
// load-use / memory-wait stalls and debug halt with a fixed drain window.
module pipe_ctrl #(
  parameter int CNT_W = 16,
  parameter int DRAIN = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_load,
  input  logic [4:0]       ex_rd,
  input  logic             taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             halt_req,
  output logic             en_if,
  output logic             en_id,
  output logic             en_ex,
  output logic             en_mem,
  output logic             en_wb,
  output logic             bubble_ex,
  output logic             flush_id,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);

  localparam int DC_W = (DRAIN < 2) ? 1 : $clog2(DRAIN + 1);
  localparam logic [DC_W-1:0] DRAIN_LD = DC_W'(DRAIN - 1);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_LDSTALL = 2'd1,
    S_MWAIT   = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [DC_W-1:0]   drain_q, drain_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  logic hz, mw;
  logic en_if_c, en_id_c, en_back_c, bubble_c, halted_c;

  assign hz = id_valid & ex_load & (ex_rd != 5'd0) &
              ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
  assign mw = mem_req & ~mem_ready;

  // MWAIT behaves exactly like RUN: it holds only while mw stays asserted.
  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    en_if_c   = 1'b0;
    en_id_c   = 1'b0;
    en_back_c = 1'b0;
    bubble_c  = 1'b0;
    halted_c  = 1'b0;
    if (state_q == S_HALT) begin
      bubble_c = 1'b1;
      if (drain_q != '0) begin
        en_back_c = 1'b1;
        drain_d   = drain_q - 1'b1;
      end else begin
        halted_c = 1'b1;
      end
      if (!halt_req) begin
        state_d = S_RUN;
        drain_d = '0;
      end
    end else if (mw) begin
      state_d = S_MWAIT;
    end else if (hz && state_q != S_LDSTALL) begin
      en_back_c = 1'b1;
      bubble_c  = 1'b1;
      state_d   = S_LDSTALL;
    end else if (halt_req) begin
      en_back_c = 1'b1;
      bubble_c  = 1'b1;
      drain_d   = DRAIN_LD;
      state_d   = S_HALT;
    end else begin
      en_if_c   = 1'b1;
      en_id_c   = 1'b1;
      en_back_c = 1'b1;
      state_d   = S_RUN;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (!en_id_c && state_q != S_HALT && stall_q != '1) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      drain_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      stall_q <= stall_d;
    end
  end

  // Outputs are combinational, so reset must force them directly.
  assign en_if       = en_if_c & ~rst;
  assign en_id       = en_id_c & ~rst;
  assign en_ex       = en_back_c & ~rst;
  assign en_mem      = en_back_c & ~rst;
  assign en_wb       = en_back_c & ~rst;
  assign bubble_ex   = bubble_c | rst;
  assign flush_id    = taken & en_id_c & ~rst;
  assign halted      = halted_c & ~rst;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios followed by random traffic, all
// checked cycle by cycle against a behavioural model of the stall rules.
module tb_pipe_ctrl;
  localparam int CNT_W = 4;
  localparam int DRAIN = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid, id_uses_rs1, id_uses_rs2, ex_load, taken;
  logic             mem_req, mem_ready, halt_req;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             en_if, en_id, en_ex, en_mem, en_wb, bubble_ex, flush_id, halted;
  logic [CNT_W-1:0] stall_count;

  int total = 0;
  int bad   = 0;

  // model: halt mode with drain cycles left, whether last cycle was a load-use stall
  bit m_halt;
  int m_drain;
  bit m_prev_ld;
  int m_stalls;

  pipe_ctrl #(.CNT_W(CNT_W), .DRAIN(DRAIN)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_load(ex_load), .ex_rd(ex_rd), .taken(taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .halt_req(halt_req),
    .en_if(en_if), .en_id(en_id), .en_ex(en_ex), .en_mem(en_mem), .en_wb(en_wb),
    .bubble_ex(bubble_ex), .flush_id(flush_id), .halted(halted),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_halt = 0; m_drain = 0; m_prev_ld = 0; m_stalls = 0;
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_load = 0; ex_rd = 0; taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic set_hz();
    id_valid = 1; ex_load = 1; ex_rd = 5; id_uses_rs1 = 1; id_rs1 = 5;
  endtask

  task automatic eval_and_advance();
    bit hz, mw, e_if, e_id, e_ex, bub, hal, chk_bub;
    hz = id_valid && ex_load && (ex_rd != 0) &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    mw = mem_req && !mem_ready;
    chk_bub = 1; hal = 0;
    if (m_halt) begin
      e_if = 0; e_id = 0; e_ex = (m_drain > 0); bub = 1; hal = (m_drain == 0);
    end else if (mw) begin
      e_if = 0; e_id = 0; e_ex = 0; bub = 0; chk_bub = 0;
    end else if ((hz && !m_prev_ld) || halt_req) begin
      e_if = 0; e_id = 0; e_ex = 1; bub = 1;
    end else begin
      e_if = 1; e_id = 1; e_ex = 1; bub = 0;
    end
    chk("en_if", en_if, e_if);
    chk("en_id", en_id, e_id);
    chk("en_ex", en_ex, e_ex);
    chk("en_mem", en_mem, e_ex);
    chk("en_wb", en_wb, e_ex);
    if (chk_bub) chk("bubble_ex", bubble_ex, bub);
    chk("flush_id", flush_id, taken && e_id);
    chk("halted", halted, hal);
    chk("stall_count", stall_count, m_stalls);

    if (!m_halt && !e_id && m_stalls < (1 << CNT_W) - 1) m_stalls++;
    if (m_halt) begin
      if (!halt_req) begin m_halt = 0; m_drain = 0; end
      else if (m_drain > 0) m_drain--;
      m_prev_ld = 0;
    end else if (mw) begin
      m_prev_ld = 0;
    end else if (hz && !m_prev_ld) begin
      m_prev_ld = 1;
    end else if (halt_req) begin
      m_halt = 1; m_drain = DRAIN - 1; m_prev_ld = 0;
    end else begin
      m_prev_ld = 0;
    end
  endtask

  task automatic cyc();
    #1;
    eval_and_advance();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    idle();
    halt_req = 0;
    taken = 1;
    rst = 1;
    m_reset();
    #2;
    chk("rst_en_if", en_if, 0);
    chk("rst_en_id", en_id, 0);
    chk("rst_en_ex", en_ex, 0);
    chk("rst_en_mem", en_mem, 0);
    chk("rst_en_wb", en_wb, 0);
    chk("rst_bubble", bubble_ex, 1);
    chk("rst_flush", flush_id, 0);
    chk("rst_halted", halted, 0);
    chk("rst_cnt", stall_count, 0);
    @(negedge clk);
    rst = 0;
    idle();
    cyc();

    // load-use: one stall, second hz in LDSTALL ignored
    set_hz(); cyc(); cyc();
    idle(); cyc();
    chk("lu_cnt", stall_count, 1);

    // x0 and unused source never stall
    ex_load = 1; ex_rd = 0; id_valid = 1; id_uses_rs1 = 1; id_rs1 = 0; cyc();
    ex_rd = 7; id_rs2 = 7; id_uses_rs2 = 0; id_rs1 = 3; cyc();
    idle();

    // four wait states, then ready
    mem_req = 1; mem_ready = 0;
    repeat (4) cyc();
    mem_ready = 1; cyc();
    idle(); cyc();
    chk("mw_cnt", stall_count, 5);

    // coincident hz and mw: MWAIT first, then one load-use stall
    set_hz(); mem_req = 1; mem_ready = 0; cyc(); cyc();
    mem_ready = 1; cyc();
    mem_req = 0; cyc();
    idle(); cyc();
    chk("co_cnt", stall_count, 8);

    // branch flush only when ID advances
    taken = 1; cyc();
    set_hz(); taken = 1; cyc();
    idle(); cyc();

    // full halt and drain, then resume
    halt_req = 1; repeat (6) cyc();
    halt_req = 0; cyc(); cyc();
    // halt dropped after one drain cycle
    halt_req = 1; cyc(); cyc();
    halt_req = 0; cyc(); cyc();

    // asynchronous reset between edges while in MWAIT
    mem_req = 1; mem_ready = 0; cyc(); cyc();
    #2 rst = 1;
    #1;
    chk("arst_en_if", en_if, 0);
    chk("arst_en_ex", en_ex, 0);
    chk("arst_cnt", stall_count, 0);
    chk("arst_bubble", bubble_ex, 1);
    m_reset();
    @(negedge clk);
    rst = 0;
    idle(); cyc(); cyc();

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) == 0) begin
        rst = 1;
        #1;
        chk("rrst_en_id", en_id, 0);
        chk("rrst_cnt", stall_count, 0);
        m_reset();
        @(negedge clk);
        rst = 0;
      end
      id_valid    = ($urandom_range(3) != 0);
      id_rs1      = 5'($urandom_range(3));
      id_rs2      = 5'($urandom_range(3));
      id_uses_rs1 = 1'($urandom_range(1));
      id_uses_rs2 = 1'($urandom_range(1));
      ex_load     = 1'($urandom_range(1));
      ex_rd       = 5'($urandom_range(3));
      taken       = ($urandom_range(3) == 0);
      mem_req     = ($urandom_range(3) == 0);
      mem_ready   = ($urandom_range(2) == 0);
      if ($urandom_range(15) == 0) halt_req = ~halt_req;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
